uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  input  1  global advance; low freezes all state, counters and outputs.
REQ-006 SHALL have port isStart  input  1  word valid; transfer occurs on an edge where isStart=1 and ready=1.
REQ-007 SHALL have port data  input  DATA_W  word to send, LSB first.
REQ-008 SHALL have port parMode  input  2  parity per word: 00 none, 01 even, 10 odd, 11 mark (always 1).
REQ-009 SHALL have port twoStop  input  1  per word: 0 one stop bit, 1 two stop bits.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port ready  output  1  combinational, = enable AND holding register empty.
REQ-012 SHALL have port busy  output  1  high while any frame is on the line or a word is pending.
REQ-013 SHALL have port isFinish  output  1  one-cycle pulse on completion of each frame.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL capture data, parMode and twoStop together on transfer; later input changes do not affect that word.
REQ-016 SHALL, on transfer in IDLE at edge N, load the shifter directly and drive tx=0 (START) from edge N+1.
REQ-017 SHALL, on transfer while not IDLE, store the word in a one-entry holding register; ready falls the next cycle.
REQ-018 SHALL hold each bit on tx for exactly CLKS_PER_BIT enabled cycles, via a baud counter 0..CLKS_PER_BIT-1 reset at every bit boundary.
REQ-019 SHALL send frame: START (0), DATA_W data bits LSB first, PARITY bit if parMode!=00, one or two STOP bits (1).
REQ-020 SHALL compute parity as even = XOR of data bits, odd = NOT XOR, mark = 1; skip PARITY when parMode=00.
REQ-021 SHALL, at end of the final STOP bit with holding full, move the holding word to the shifter and enter START on the next edge with no idle bit; holding becomes empty.
REQ-022 SHALL, at end of the final STOP bit with holding empty, return to IDLE with tx=1 and busy=0.
REQ-023 SHALL pulse isFinish high for exactly one cycle on the edge the final STOP bit completes, including back-to-back frames.
REQ-024 SHALL, with enable=0, freeze state, bit and baud counters, hold tx, force ready=0, ignore isStart and keep isFinish low.
REQ-025 SHALL leave frame timing unaffected by isStart activity, except via the holding-register path.
REQ-026 SHALL treat frame length in enabled cycles as CLKS_PER_BIT*(1+DATA_W+P+S), where P = (parMode!=00), S = 1+twoStop.

Reset
REQ-027 SHALL, on an edge with rst_n=0, regardless of enable: state IDLE, tx=1, busy=0, isFinish=0, holding empty, all counters 0.
REQ-028 SHALL, on reset mid-frame, abort the frame and discard any pending word; tx=1 from the reset edge on.
REQ-029 SHALL have ready=1 after reset whenever enable=1.

Verification
REQ-030 SHALL cover single frame: DATA_W=8, CLKS_PER_BIT=4, data=0xA5, parMode=01, twoStop=0 -> tx bits 0,1,0,1,0,0,1,0,1,0,1 each 4 cycles; isFinish at cycle 44 after START; then idle.
REQ-031 SHALL cover odd parity: data=0x00, parMode=10 -> parity bit 1; data=0x07, parMode=10 -> parity bit 0.
REQ-032 SHALL cover no parity with two stops: data=0xFF, parMode=00, twoStop=1 -> 11 bits (0, eight 1s, 1, 1), 44 cycles, no PARITY state.
REQ-033 SHALL cover back-to-back: 0x12 then 0x34 accepted mid-frame -> ready low until second frame starts; second START immediately follows first STOP; two isFinish pulses 44 cycles apart.
REQ-034 SHALL cover enable stall: enable=0 for 10 cycles during DATA bit 3 -> tx held, frame completes 10 cycles late, bit values unchanged.
REQ-035 SHALL cover reset mid-frame with word pending: rst_n=0 for 1 cycle during DATA -> tx=1, busy=0, ready=1 next cycle; pending word never transmitted.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART transmitter with a one-word holding register.
// Sends START (0), DATA_W data bits LSB first, optional parity, then one or two
// STOP bits (1). Each bit lasts CLKS_PER_BIT enabled clock cycles.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   enable    global advance; low freezes all state and forces ready low
//   isStart   word valid; a transfer happens when isStart and ready are both high
//   data      word to send, LSB first
//   parMode   parity: 00 none, 01 even, 10 odd, 11 mark
//   twoStop   0 one stop bit, 1 two stop bits
//   tx        serial line, idle high
//   ready     enable and holding register empty (combinational)
//   busy      frame on the line or word pending
//   isFinish  one-cycle pulse when the final stop bit completes
module uart_tx_gen #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              isStart,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        parMode,
  input  logic              twoStop,
  output logic              tx,
  output logic              ready,
  output logic              busy,
  output logic              isFinish
);

  localparam int unsigned BitW  = $clog2(DATA_W);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e              state_q;
  logic [BaudW-1:0]    baud_q;
  logic [BitW-1:0]     bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                two_q;
  logic                tx_q;
  logic                fin_q;
  logic                hold_valid_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [1:0]          hold_mode_q;
  logic                hold_two_q;

  logic                xfer;
  logic                bit_end;
  logic                last_stop;
  logic [DATA_W-1:0]   ld_data;
  logic [1:0]          ld_mode;
  logic                ld_two;

  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] m);
    logic p;
    case (m)
      2'b01:   p = ^d;
      2'b10:   p = ~(^d);
      default: p = 1'b1;  // mark; unused when parity is off
    endcase
    return p;
  endfunction

  assign ready   = enable & ~hold_valid_q;
  assign busy    = (state_q != StIdle) | hold_valid_q;
  assign tx      = tx_q;
  assign isFinish = fin_q;

  assign xfer      = isStart & ready;
  assign bit_end   = (baud_q == BaudLast);
  assign last_stop = (state_q == StStop) && bit_end && (!two_q || (bit_q == BitW'(1)));

  // A pending word always takes precedence over the live inputs when a frame is
  // (re)started; in IDLE the holding register is empty so the inputs are used.
  assign ld_data = hold_valid_q ? hold_data_q : data;
  assign ld_mode = hold_valid_q ? hold_mode_q : parMode;
  assign ld_two  = hold_valid_q ? hold_two_q  : twoStop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      two_q        <= 1'b0;
      tx_q         <= 1'b1;
      fin_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_mode_q  <= '0;
      hold_two_q   <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (enable) begin
        // Words arriving mid-frame park in the holding register, except on the
        // final stop edge, where an arriving word starts the next frame directly.
        if (xfer && (state_q != StIdle) && !last_stop) begin
          hold_valid_q <= 1'b1;
          hold_data_q  <= data;
          hold_mode_q  <= parMode;
          hold_two_q   <= twoStop;
        end

        if (state_q != StIdle) begin
          baud_q <= bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
          StIdle: begin
            if (xfer) begin
              shift_q   <= ld_data;
              par_en_q  <= (ld_mode != 2'b00);
              par_bit_q <= parity_of(ld_data, ld_mode);
              two_q     <= ld_two;
              state_q   <= StStart;
              tx_q      <= 1'b0;
              baud_q    <= '0;
            end
          end
          StStart: begin
            if (bit_end) begin
              state_q <= StData;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= '0;
            end
          end
          StData: begin
            if (bit_end) begin
              if (bit_q == BitLast) begin
                bit_q <= '0;
                if (par_en_q) begin
                  state_q <= StParity;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q <= StStop;
                  tx_q    <= 1'b1;
                end
              end else begin
                tx_q    <= shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= bit_q + 1'b1;
              end
            end
          end
          StParity: begin
            if (bit_end) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
              bit_q   <= '0;
            end
          end
          StStop: begin
            if (bit_end) begin
              if (!last_stop) begin
                bit_q <= BitW'(1);
              end else begin
                fin_q <= 1'b1;
                bit_q <= '0;
                if (hold_valid_q || xfer) begin
                  shift_q      <= ld_data;
                  par_en_q     <= (ld_mode != 2'b00);
                  par_bit_q    <= parity_of(ld_data, ld_mode);
                  two_q        <= ld_two;
                  hold_valid_q <= 1'b0;
                  state_q      <= StStart;
                  tx_q         <= 1'b0;
                end else begin
                  state_q <= StIdle;
                  tx_q    <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen with DATA_W=8, CLKS_PER_BIT=4.
// Expected frames are hand-written bit vectors: bit i is the i-th bit on the line.
module tb_uart_tx_gen;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          isStart = 1'b0;
  logic [DW-1:0] data = '0;
  logic [1:0]    parMode = '0;
  logic          twoStop = 1'b0;
  logic          tx;
  logic          ready;
  logic          busy;
  logic          isFinish;

  int n_checks = 0;
  int n_fail = 0;
  int ready_low = 0;
  int tx_low = 0;

  // 0xA5 even parity, one stop: 0,1,0,1,0,0,1,0,1,0,1
  localparam logic [15:0] FrA5Even = 16'b00000_10101001010;
  // 0x00 odd parity: parity 1
  localparam logic [15:0] Fr00Odd  = 16'b00000_11000000000;
  // 0x07 odd parity: parity 0
  localparam logic [15:0] Fr07Odd  = 16'b00000_10000001110;
  // 0xFF no parity, two stops
  localparam logic [15:0] FrFFTwo  = 16'b00000_11111111110;
  // 0x12 even parity: parity 0
  localparam logic [15:0] Fr12Even = 16'b00000_10000100100;
  // 0x34 even parity: parity 1
  localparam logic [15:0] Fr34Even = 16'b00000_11001101000;

  always #5 clk = ~clk;

  uart_tx_gen #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .isStart (isStart),
    .data    (data),
    .parMode (parMode),
    .twoStop (twoStop),
    .tx      (tx),
    .ready   (ready),
    .busy    (busy),
    .isFinish(isFinish)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one edge, then scramble the inputs to prove capture.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] pm, input logic tw);
    data    = d;
    parMode = pm;
    twoStop = tw;
    isStart = 1'b1;
    step();
    isStart = 1'b0;
    data    = ~d;
    parMode = ~pm;
    twoStop = ~tw;
  endtask

  // Called at the first cycle of a frame; leaves off at the cycle after it ends.
  task automatic expect_bits(input logic [15:0] bits, input int n, input logic fin0,
                             input string tag);
    for (int i = 0; i < n * CPB; i++) begin
      check({tag, "_tx"}, 32'(tx), 32'(bits[i / CPB]));
      check({tag, "_fin"}, 32'(isFinish), (i == 0) ? 32'(fin0) : 32'(0));
      if (!ready) ready_low++;
      step();
      isStart = 1'b0;
    end
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_end_fin"}, 32'(isFinish), 32'(1));
    check({tag, "_end_tx"}, 32'(tx), 32'(1));
    check({tag, "_end_busy"}, 32'(busy), 32'(0));
    check({tag, "_end_ready"}, 32'(ready), 32'(1));
    step();
    check({tag, "_fin_drop"}, 32'(isFinish), 32'(0));
    check({tag, "_idle_tx"}, 32'(tx), 32'(1));
  endtask

  initial begin
    // Reset
    rst_n  = 1'b0;
    enable = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_fin", 32'(isFinish), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    enable = 1'b0;
    #1;
    check("ready_disabled", 32'(ready), 32'(0));
    enable = 1'b1;
    step();

    // Single frame, even parity; tx low right after the transfer edge
    send(8'hA5, 2'b01, 1'b0);
    check("a5_busy", 32'(busy), 32'(1));
    check("a5_ready", 32'(ready), 32'(1));
    expect_bits(FrA5Even, 11, 1'b0, "a5");
    end_frame("a5");

    // Odd parity
    send(8'h00, 2'b10, 1'b0);
    expect_bits(Fr00Odd, 11, 1'b0, "odd00");
    end_frame("odd00");
    send(8'h07, 2'b10, 1'b0);
    expect_bits(Fr07Odd, 11, 1'b0, "odd07");
    end_frame("odd07");

    // No parity, two stops: still 44 cycles
    send(8'hFF, 2'b00, 1'b1);
    expect_bits(FrFFTwo, 11, 1'b0, "ff2");
    end_frame("ff2");

    // Back-to-back: second word captured on the edge after the first starts
    send(8'h12, 2'b01, 1'b0);
    data      = 8'h34;
    parMode   = 2'b01;
    twoStop   = 1'b0;
    isStart   = 1'b1;
    ready_low = 0;
    expect_bits(Fr12Even, 11, 1'b0, "b2b1");
    check("b2b_ready_low", 32'(ready_low), 32'(43));
    check("b2b_busy", 32'(busy), 32'(1));
    expect_bits(Fr34Even, 11, 1'b1, "b2b2");
    end_frame("b2b2");

    // Enable stall for 10 cycles during data bit 3 (line bit 4)
    send(8'hA5, 2'b01, 1'b0);
    for (int i = 0; i < 11 * CPB; i++) begin
      check("stall_tx", 32'(tx), 32'(FrA5Even[i / CPB]));
      check("stall_fin", 32'(isFinish), 32'(0));
      if (i == 17) begin
        enable = 1'b0;
        repeat (10) begin
          step();
          check("stall_hold_tx", 32'(tx), 32'(FrA5Even[4]));
          check("stall_hold_ready", 32'(ready), 32'(0));
          check("stall_hold_fin", 32'(isFinish), 32'(0));
        end
        enable = 1'b1;
      end
      step();
    end
    end_frame("stall");

    // Reset mid-frame with a word pending
    send(8'h12, 2'b01, 1'b0);
    data    = 8'h34;
    parMode = 2'b01;
    isStart = 1'b1;
    step();
    isStart = 1'b0;
    check("mid_hold_ready", 32'(ready), 32'(0));
    repeat (8) step();
    check("mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_tx", 32'(tx), 32'(1));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(ready), 32'(1));
    check("mid_rst_fin", 32'(isFinish), 32'(0));
    tx_low = 0;
    repeat (60) begin
      if (!tx) tx_low++;
      step();
    end
    check("mid_no_pending_tx", 32'(tx_low), 32'(0));
    check("mid_final_busy", 32'(busy), 32'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
